// File: rtl/slurm32_pipeline_seq_if.sv
// Instruction-fetch port between the SLURM32 pipeline sequencer (master)
// and the instruction cache (slave).
interface slurm32_pipeline_seq_if #(
  parameter int BITS         = 32,
  parameter int ADDRESS_BITS = 32
);
  logic                    instruction_request;
  logic                    instruction_valid;
  logic [ADDRESS_BITS-1:0] instruction_address;
  logic [BITS-1:0]         instruction_in;

  modport master (
    output instruction_request,
    output instruction_address,
    input  instruction_valid,
    input  instruction_in
  );

  modport slave (
    input  instruction_request,
    input  instruction_address,
    output instruction_valid,
    output instruction_in
  );
endinterface

// File: rtl/slurm32_pipeline_seq.sv
// SLURM32 pipeline sequencer: fetch PC, instruction/PC shift register of
// STAGES slots and the control FSM handling fetch misses, hazard stalls,
// memory-fault replay, interrupt injection, branch flush and halt.
//
// prev_pc always names the fetch address of the word currently in slot 0
// (or the point to resume from when slot 0 is a bubble), so any path that
// drops slot 0 rewinds the PC to prev_pc. A hazard drops slot 0 on the very
// edge it is seen, so the decode slot is frozen for exactly STALL_CYCLES
// edges. When ISTALL2 finally accepts a word it advances the PC like a
// normal EXEC fetch, so the refetched word is not fetched twice.
module slurm32_pipeline_seq #(
  parameter int              BITS         = 32,
  parameter int              ADDRESS_BITS = 32,
  parameter int              STAGES       = 5,
  parameter int              STALL_CYCLES = 3,
  parameter int              FLUSH_DEPTH  = 2,
  parameter logic [BITS-1:0] NOP          = 32'h0000_0000
) (
  input  logic                                CLK,
  input  logic                                RSTb,
  slurm32_pipeline_seq_if.master              fetch,
  output logic [STAGES*BITS-1:0]              stage_flat,
  output logic [STAGES*(ADDRESS_BITS-2)-1:0]  pc_flat,
  input  logic                                hazard_stall,
  input  logic                                halt_request,
  input  logic                                debugger_halt_request,
  input  logic                                interrupt,
  input  logic [3:0]                          irq,
  input  logic                                interrupt_flag_set,
  input  logic                                interrupt_flag_clear,
  input  logic                                load_pc_request,
  input  logic [ADDRESS_BITS-1:0]             load_pc_address,
  input  logic                                debugger_load_pc_request,
  input  logic [ADDRESS_BITS-1:0]             debugger_load_pc_address,
  input  logic                                memory_request_successful,
  output logic [3:0]                          state,
  output logic                                interrupt_flag
);

  localparam int PCW = ADDRESS_BITS - 2;

  typedef enum logic [3:0] {
    ST_RESET   = 4'd0,
    ST_HALT    = 4'd1,
    ST_EXEC    = 4'd2,
    ST_INTR    = 4'd3,
    ST_STALL   = 4'd4,
    ST_ISTALL1 = 4'd7,
    ST_ISTALL2 = 4'd8,
    ST_MEMX    = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    SL_HOLD  = 2'd0,
    SL_SHIFT = 2'd1,
    SL_STALL = 2'd2,
    SL_CLEAR = 2'd3
  } slot_mode_t;

  state_t           state_q, state_d;
  state_t           return_q, return_d;
  logic [PCW-1:0]   pc_q, pc_d;
  logic [PCW-1:0]   prev_pc_q, prev_pc_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             req_q, req_d;
  logic [BITS-1:0]  stage_q [STAGES];
  logic [BITS-1:0]  stage_d [STAGES];
  logic [PCW-1:0]   spc_q [STAGES];
  logic [PCW-1:0]   spc_d [STAGES];

  slot_mode_t       slot_mode_s;
  logic [BITS-1:0]  slot0_word_s;
  logic             flush_branch_s;
  logic [PCW-1:0]   pc_inc_s;
  logic [BITS-1:0]  fetch_word_s;
  logic [BITS-1:0]  intr_word_s;
  logic [3:0]       last_op_s;
  logic             mem_op_s;
  logic             mem_fault_s;
  logic             addr_lsb_unused_s;

  assign pc_inc_s     = pc_q + PCW'(1);
  assign fetch_word_s = fetch.instruction_valid ? fetch.instruction_in : NOP;
  assign intr_word_s  = BITS'({28'h050_0000, irq});
  assign last_op_s    = stage_q[STAGES-1][BITS-1 -: 4];
  assign mem_op_s     = (last_op_s == 4'h8) || (last_op_s == 4'hC) || (last_op_s == 4'hD);
  assign mem_fault_s  = mem_op_s && !memory_request_successful;
  assign addr_lsb_unused_s = ^{load_pc_address[1:0], debugger_load_pc_address[1:0]};

  // Control FSM: next state, PC bookkeeping and how the slots move this cycle.
  always_comb begin
    state_d        = state_q;
    return_d       = return_q;
    pc_d           = pc_q;
    prev_pc_d      = prev_pc_q;
    cnt_d          = cnt_q;
    slot_mode_s    = SL_HOLD;
    slot0_word_s   = NOP;
    flush_branch_s = 1'b0;
    if ((state_q != ST_RESET) && mem_fault_s) begin
      // Drop everything and replay from the faulting instruction.
      state_d     = ST_MEMX;
      pc_d        = spc_q[STAGES-1];
      prev_pc_d   = spc_q[STAGES-1];
      slot_mode_s = SL_CLEAR;
      case (state_q)
        ST_INTR: return_d = ST_INTR;
        ST_HALT: return_d = ST_HALT;
        default: return_d = ST_EXEC;
      endcase
    end else begin
      case (state_q)
        ST_RESET: begin
          state_d = ST_EXEC;
        end
        ST_EXEC: begin
          if (load_pc_request) begin
            pc_d           = load_pc_address[ADDRESS_BITS-1:2];
            prev_pc_d      = load_pc_address[ADDRESS_BITS-1:2];
            slot_mode_s    = SL_SHIFT;
            flush_branch_s = 1'b1;
          end else if (interrupt && flag_q) begin
            slot_mode_s  = SL_SHIFT;
            slot0_word_s = fetch_word_s;
            state_d      = ST_INTR;
            if (fetch.instruction_valid) begin
              pc_d      = pc_inc_s;
              prev_pc_d = pc_q;
            end else begin
              pc_d      = pc_q;
            end
          end else if (!fetch.instruction_valid) begin
            slot_mode_s = SL_SHIFT;
            pc_d        = pc_inc_s;
            prev_pc_d   = pc_q;
            state_d     = ST_ISTALL1;
          end else if (hazard_stall) begin
            slot_mode_s = SL_STALL;
            pc_d        = prev_pc_q;
            cnt_d       = 3'(STALL_CYCLES - 1);
            state_d     = (STALL_CYCLES > 1) ? ST_STALL : ST_EXEC;
          end else if (halt_request || debugger_halt_request) begin
            slot_mode_s  = SL_SHIFT;
            slot0_word_s = fetch_word_s;
            pc_d         = pc_inc_s;
            prev_pc_d    = pc_q;
            state_d      = ST_HALT;
          end else begin
            slot_mode_s  = SL_SHIFT;
            slot0_word_s = fetch_word_s;
            pc_d         = pc_inc_s;
            prev_pc_d    = pc_q;
          end
        end
        ST_ISTALL1: begin
          slot_mode_s = SL_SHIFT;
          pc_d        = prev_pc_q;
          state_d     = ST_ISTALL2;
        end
        ST_ISTALL2: begin
          slot_mode_s  = SL_SHIFT;
          slot0_word_s = fetch_word_s;
          if (fetch.instruction_valid) begin
            pc_d      = pc_inc_s;
            prev_pc_d = pc_q;
            state_d   = ST_EXEC;
          end else begin
            pc_d      = pc_q;
          end
        end
        ST_STALL: begin
          slot_mode_s = SL_STALL;
          pc_d        = prev_pc_q;
          cnt_d       = cnt_q - 3'd1;
          state_d     = (cnt_q <= 3'd1) ? ST_EXEC : ST_STALL;
        end
        ST_INTR: begin
          slot_mode_s  = SL_SHIFT;
          slot0_word_s = intr_word_s;
          prev_pc_d    = pc_q;
          state_d      = flag_q ? ST_INTR : ST_EXEC;
        end
        ST_HALT: begin
          if (debugger_load_pc_request) begin
            pc_d      = debugger_load_pc_address[ADDRESS_BITS-1:2];
            prev_pc_d = debugger_load_pc_address[ADDRESS_BITS-1:2];
          end else begin
            pc_d      = pc_q;
          end
          state_d = interrupt ? ST_EXEC : ST_HALT;
        end
        ST_MEMX: begin
          slot_mode_s = SL_CLEAR;
          state_d     = return_q;
        end
        default: begin
          state_d = ST_RESET;
        end
      endcase
    end
  end

  // Slot shift register: shift, stall (freeze decode slot), clear or hold.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stage_d[k] = stage_q[k];
      spc_d[k]   = spc_q[k];
    end
    case (slot_mode_s)
      SL_SHIFT: begin
        stage_d[0] = flush_branch_s ? NOP : slot0_word_s;
        spc_d[0]   = pc_q;
        for (int k = 1; k < STAGES; k++) begin
          stage_d[k] = (flush_branch_s && (k < FLUSH_DEPTH)) ? NOP : stage_q[k-1];
          spc_d[k]   = spc_q[k-1];
        end
      end
      SL_STALL: begin
        stage_d[0] = NOP;
        spc_d[0]   = pc_q;
        stage_d[2] = NOP;
        spc_d[2]   = spc_q[1];
        for (int k = 3; k < STAGES; k++) begin
          stage_d[k] = stage_q[k-1];
          spc_d[k]   = spc_q[k-1];
        end
      end
      SL_CLEAR: begin
        for (int k = 0; k < STAGES; k++) begin
          stage_d[k] = NOP;
        end
      end
      default: begin
        stage_d[0] = stage_q[0];
      end
    endcase
  end

  // Interrupt flag (set wins over clear) and fetch-request strobe for next cycle.
  always_comb begin
    flag_d = interrupt_flag_set ? 1'b1 : (interrupt_flag_clear ? 1'b0 : flag_q);
    req_d  = (state_d == ST_EXEC) || (state_d == ST_ISTALL2);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state_q   <= ST_RESET;
      return_q  <= ST_EXEC;
      pc_q      <= '0;
      prev_pc_q <= '0;
      cnt_q     <= 3'd0;
      flag_q    <= 1'b0;
      req_q     <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= NOP;
        spc_q[k]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      return_q  <= return_d;
      pc_q      <= pc_d;
      prev_pc_q <= prev_pc_d;
      cnt_q     <= cnt_d;
      flag_q    <= flag_d;
      req_q     <= req_d;
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= stage_d[k];
        spc_q[k]   <= spc_d[k];
      end
    end
  end

  // Flatten slot contents and slot PCs onto the output buses.
  always_comb begin
    stage_flat = '0;
    pc_flat    = '0;
    for (int k = 0; k < STAGES; k++) begin
      stage_flat[k*BITS +: BITS] = stage_q[k];
      pc_flat[k*PCW +: PCW]      = spc_q[k];
    end
  end

  assign fetch.instruction_request = req_q;
  assign fetch.instruction_address = {pc_q, 2'b00};
  assign state                     = state_q;
  assign interrupt_flag            = flag_q;

endmodule

// File: tb/tb_slurm32_pipeline_seq.sv
// Directed bench for slurm32_pipeline_seq (STAGES=6, FLUSH_DEPTH=2,
// STALL_CYCLES=3). The fetch port is served by a small memory model: word i
// is 32'h1000_0000+i, except word 7 which is the memory op 32'h8000_0007.
module tb_slurm32_pipeline_seq;
  localparam int BITS = 32;
  localparam int AB   = 32;
  localparam int ST   = 6;

  logic CLK = 1'b0;
  logic RSTb;
  logic valid_en;
  logic hazard_stall, halt_request, debugger_halt_request, interrupt;
  logic [3:0] irq;
  logic interrupt_flag_set, interrupt_flag_clear;
  logic load_pc_request, debugger_load_pc_request, memory_request_successful;
  logic [AB-1:0] load_pc_address, debugger_load_pc_address;
  logic [ST*BITS-1:0] stage_flat;
  logic [ST*(AB-2)-1:0] pc_flat;
  logic [3:0] state;
  logic interrupt_flag;
  int n_cmp = 0;
  int n_bad = 0;

  slurm32_pipeline_seq_if #(.BITS(BITS), .ADDRESS_BITS(AB)) fif ();

  slurm32_pipeline_seq #(
    .BITS(BITS), .ADDRESS_BITS(AB), .STAGES(ST), .STALL_CYCLES(3),
    .FLUSH_DEPTH(2), .NOP(32'h0000_0000)
  ) dut (
    .CLK(CLK), .RSTb(RSTb), .fetch(fif.master),
    .stage_flat(stage_flat), .pc_flat(pc_flat),
    .hazard_stall(hazard_stall), .halt_request(halt_request),
    .debugger_halt_request(debugger_halt_request),
    .interrupt(interrupt), .irq(irq),
    .interrupt_flag_set(interrupt_flag_set), .interrupt_flag_clear(interrupt_flag_clear),
    .load_pc_request(load_pc_request), .load_pc_address(load_pc_address),
    .debugger_load_pc_request(debugger_load_pc_request),
    .debugger_load_pc_address(debugger_load_pc_address),
    .memory_request_successful(memory_request_successful),
    .state(state), .interrupt_flag(interrupt_flag)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] word_at(input logic [29:0] idx);
    if (idx == 30'd7) return 32'h8000_0007;
    return 32'h1000_0000 | {2'b00, idx};
  endfunction

  assign fif.instruction_in    = word_at(fif.instruction_address[31:2]);
  assign fif.instruction_valid = valid_en;

  function automatic logic [31:0] slot(input int k);
    return stage_flat[k*BITS +: BITS];
  endfunction

  function automatic logic [29:0] spc(input int k);
    return pc_flat[k*(AB-2) +: (AB-2)];
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    valid_en = 1'b1; hazard_stall = 1'b0; halt_request = 1'b0;
    debugger_halt_request = 1'b0; interrupt = 1'b0; irq = 4'd0;
    interrupt_flag_set = 1'b0; interrupt_flag_clear = 1'b0;
    load_pc_request = 1'b0; load_pc_address = 32'd0;
    debugger_load_pc_request = 1'b0; debugger_load_pc_address = 32'd0;
    memory_request_successful = 1'b1;
  endtask

  // Reset, then release: returns just after the RESET->EXEC edge (pc 0).
  task automatic do_reset();
    clear_inputs();
    RSTb = 1'b0;
    tick();
    RSTb = 1'b1;
    tick();
  endtask

  initial begin
    clear_inputs();
    valid_en = 1'b0;
    RSTb = 1'b0;
    tick();
    tick();
    // Reset state
    chk("rst_state", 256'(state), 256'd0);
    chk("rst_slots", 256'(stage_flat), 256'd0);
    chk("rst_pcs", 256'(pc_flat), 256'd0);
    chk("rst_addr", 256'(fif.instruction_address), 256'd0);
    chk("rst_flag", 256'(interrupt_flag), 256'd0);
    chk("rst_req", 256'(fif.instruction_request), 256'd0);
    RSTb = 1'b1;
    valid_en = 1'b1;
    tick();
    chk("exec_state", 256'(state), 256'd2);
    chk("exec_req", 256'(fif.instruction_request), 256'd1);

    // Straight-line fill: address steps by 4, word 0 reaches slot 4 at cycle 5
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("fill_addr", 256'(fif.instruction_address), 256'(c * 4));
      chk("fill_slot0", 256'(slot(0)), 256'(32'h1000_0000 + c - 1));
    end
    chk("fill_slot4", 256'(slot(4)), 256'(32'h1000_0000));
    chk("fill_pc4", 256'(spc(4)), 256'd0);

    // Fetch miss at pc 3
    do_reset();
    tick(); tick(); tick();
    chk("miss_addr", 256'(fif.instruction_address), 256'd12);
    valid_en = 1'b0;
    tick();
    chk("miss_istall1", 256'(state), 256'd7);
    chk("miss_slot0", 256'(slot(0)), 256'd0);
    chk("miss_slot1", 256'(slot(1)), 256'(32'h1000_0002));
    valid_en = 1'b1;
    tick();
    chk("miss_istall2", 256'(state), 256'd8);
    chk("miss_readdr", 256'(fif.instruction_address), 256'd12);
    chk("miss_req", 256'(fif.instruction_request), 256'd1);
    tick();
    chk("miss_exec", 256'(state), 256'd2);
    chk("miss_refetch", 256'(slot(0)), 256'(32'h1000_0003));
    chk("miss_refetch_pc", 256'(spc(0)), 256'd3);
    chk("miss_bubble", 256'({slot(1), slot(2)}), 256'd0);
    chk("miss_slot3", 256'(slot(3)), 256'(32'h1000_0002));
    chk("miss_next", 256'(fif.instruction_address), 256'd16);

    // Hazard with word 2 in the decode slot
    do_reset();
    tick(); tick(); tick(); tick();
    chk("haz_pre_slot1", 256'(slot(1)), 256'(32'h1000_0002));
    hazard_stall = 1'b1;
    tick();
    hazard_stall = 1'b0;
    chk("haz_state", 256'(state), 256'd4);
    chk("haz_slot3", 256'(slot(3)), 256'(32'h1000_0001));
    for (int c = 0; c < 3; c++) begin
      if (c > 0) tick();
      chk("haz_hold_slot1", 256'(slot(1)), 256'(32'h1000_0002));
      chk("haz_nop_slot2", 256'(slot(2)), 256'd0);
      chk("haz_pc_hold", 256'(fif.instruction_address), 256'd12);
    end
    chk("haz_back_exec", 256'(state), 256'd2);
    tick();
    chk("haz_resume_slot2", 256'(slot(2)), 256'(32'h1000_0002));
    chk("haz_resume_slot0", 256'(slot(0)), 256'(32'h1000_0003));
    chk("haz_resume_addr", 256'(fif.instruction_address), 256'd16);

    // Memory fault on word 7 (memory op) in the last slot
    do_reset();
    memory_request_successful = 1'b0;
    for (int c = 0; c < 13; c++) tick();
    chk("mf_pre_state", 256'(state), 256'd2);
    chk("mf_pre_last", 256'(slot(5)), 256'(32'h8000_0007));
    chk("mf_pre_pc", 256'(spc(5)), 256'd7);
    tick();
    memory_request_successful = 1'b1;
    chk("mf_memx", 256'(state), 256'd9);
    chk("mf_flush", 256'(stage_flat), 256'd0);
    chk("mf_addr", 256'(fif.instruction_address), 256'd28);
    chk("mf_noreq", 256'(fif.instruction_request), 256'd0);
    tick();
    chk("mf_exec", 256'(state), 256'd2);
    chk("mf_refetch_addr", 256'(fif.instruction_address), 256'd28);
    chk("mf_refetch_req", 256'(fif.instruction_request), 256'd1);
    tick();
    chk("mf_refetch_word", 256'(slot(0)), 256'(32'h8000_0007));

    // Interrupt injection
    do_reset();
    interrupt_flag_set = 1'b1;
    tick();
    interrupt_flag_set = 1'b0;
    chk("irq_flag_set", 256'(interrupt_flag), 256'd1);
    interrupt = 1'b1;
    irq = 4'd5;
    tick();
    chk("irq_state", 256'(state), 256'd3);
    chk("irq_entry_slot0", 256'(slot(0)), 256'(32'h1000_0001));
    tick();
    chk("irq_inject", 256'(slot(0)), 256'(32'h0500_0005));
    chk("irq_pc_hold", 256'(fif.instruction_address), 256'd8);
    tick();
    chk("irq_inject2", 256'({slot(0), slot(1)}), 256'({32'h0500_0005, 32'h0500_0005}));
    interrupt_flag_set = 1'b1;
    interrupt_flag_clear = 1'b1;
    tick();
    chk("irq_set_beats_clear", 256'(interrupt_flag), 256'd1);
    interrupt_flag_set = 1'b0;
    tick();
    interrupt_flag_clear = 1'b0;
    interrupt = 1'b0;
    chk("irq_flag_cleared", 256'(interrupt_flag), 256'd0);
    chk("irq_still_intr", 256'(state), 256'd3);
    tick();
    chk("irq_exit", 256'(state), 256'd2);
    chk("irq_exit_addr", 256'(fif.instruction_address), 256'd8);
    tick();
    chk("irq_resume", 256'(slot(0)), 256'(32'h1000_0002));

    // Branch flush, halt, debugger PC load
    do_reset();
    tick(); tick(); tick();
    load_pc_request = 1'b1;
    load_pc_address = 32'h0000_0100;
    tick();
    load_pc_request = 1'b0;
    chk("br_addr", 256'(fif.instruction_address), 256'h100);
    chk("br_flush", 256'({slot(0), slot(1)}), 256'd0);
    chk("br_keep2", 256'(slot(2)), 256'(32'h1000_0001));
    tick();
    chk("br_target_word", 256'(slot(0)), 256'(32'h1000_0040));
    halt_request = 1'b1;
    tick();
    halt_request = 1'b0;
    chk("halt_state", 256'(state), 256'd1);
    chk("halt_noreq", 256'(fif.instruction_request), 256'd0);
    tick();
    chk("halt_frozen_addr", 256'(fif.instruction_address), 256'h108);
    chk("halt_frozen_slot", 256'(slot(0)), 256'(32'h1000_0041));
    debugger_load_pc_request = 1'b1;
    debugger_load_pc_address = 32'h0000_0040;
    tick();
    debugger_load_pc_request = 1'b0;
    chk("dbg_load_addr", 256'(fif.instruction_address), 256'h40);
    chk("dbg_still_halt", 256'(state), 256'd1);
    interrupt = 1'b1;
    tick();
    interrupt = 1'b0;
    chk("halt_exit", 256'(state), 256'd2);
    tick();
    chk("dbg_resume_word", 256'(slot(0)), 256'(32'h1000_0010));
    debugger_load_pc_request = 1'b1;
    debugger_load_pc_address = 32'h0000_0080;
    tick();
    debugger_load_pc_request = 1'b0;
    chk("dbg_ignored_exec", 256'(fif.instruction_address), 256'h48);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
